imm_ext_pipe: RTL and testbench

- Parametrised, pipelined immediate generator for the ID→EX path of the pipelined MIPS core.
- Extracts the immediate, shift-amount or jump field from an instruction word and forms the operand for each extension mode.
- Registers the result through STAGES pipeline slots that obey the core's stall and flush controls.
- Flags illegal mode codes and keeps a saturating count of them for debug.

---
 rtl/ext_pkg.sv | 15 +
 rtl/imm_ext_core.sv | 31 +++
 rtl/imm_ext_pipe.sv | 53 +++++
 tb/tb_imm_ext_pipe.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// ext_pkg: ext_op encodings and pipeline entry type shared by the immediate path and the control decoder.
package ext_pkg;
  localparam logic [2:0] EXT_ZERO   = 3'd0;
  localparam logic [2:0] EXT_SIGN   = 3'd1;
  localparam logic [2:0] EXT_LUI    = 3'd2;
  localparam logic [2:0] EXT_BRANCH = 3'd3;
  localparam logic [2:0] EXT_JUMP   = 3'd4;
  localparam logic [2:0] EXT_SHAMT  = 3'd5;
  localparam int EXT_DW = 32;
  typedef struct packed {
    logic              valid;
    logic [EXT_DW-1:0] data;
    logic              err;
  } ext_entry_t;
endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational operand former; ext_op 6/7 yield zero data with err set.
module imm_ext_core import ext_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 16,
  parameter int JADDR_W = 26
) (
  input  logic [DATA_W-1:0] ins,
  input  logic [DATA_W-1:0] pc4,
  input  logic [2:0]        ext_op,
  output logic [DATA_W-1:0] data,
  output logic              err
);
  localparam logic [DATA_W-1:0] JMASK = {DATA_W{1'b1}} >> (DATA_W - JADDR_W - 2);
  logic [IMM_W-1:0]  w_imm;
  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_jmp;
  logic              w_unused;
  assign w_imm    = ins[IMM_W-1:0];
  assign w_sext   = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
  assign w_jmp    = (pc4 & ~JMASK) | (DATA_W'(ins[JADDR_W-1:0]) << 2);
  assign w_unused = ^{ins, pc4};
  always_comb begin
    data = ext_op == EXT_ZERO   ? DATA_W'(w_imm) :
           ext_op == EXT_SIGN   ? w_sext :
           ext_op == EXT_LUI    ? {w_imm, {(DATA_W-IMM_W){1'b0}}} :
           ext_op == EXT_BRANCH ? w_sext << 2 :
           ext_op == EXT_JUMP   ? w_jmp :
           ext_op == EXT_SHAMT  ? DATA_W'(ins[10:6]) : '0;
    err  = ext_op > EXT_SHAMT;
  end
endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: STAGES-deep registered immediate generator with stall/flush and a saturating illegal-op counter.
module imm_ext_pipe import ext_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 16,
  parameter int JADDR_W = 26,
  parameter int STAGES  = 1,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] ins,
  input  logic [DATA_W-1:0] pc4,
  input  logic [2:0]        ext_op,
  input  logic              err_clr,
  output logic              out_valid,
  output logic [DATA_W-1:0] imm_ext,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt
);
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              err;
  } stage_t;
  stage_t            r_stg [STAGES];
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_data;
  logic              w_err;
  imm_ext_core #(.DATA_W(DATA_W), .IMM_W(IMM_W), .JADDR_W(JADDR_W)) u_core (
    .ins(ins), .pc4(pc4), .ext_op(ext_op), .data(w_data), .err(w_err)
  );
  // Bubbles always carry zero data so the outputs need no masking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      for (int s = 0; s < STAGES; s++) r_stg[s] <= '0;
    end else if (!stall) begin
      r_stg[0] <= in_valid ? {1'b1, w_data, w_err} : '0;
      for (int s = 1; s < STAGES; s++) r_stg[s] <= r_stg[s-1];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else if (err_clr) r_cnt <= '0;
    else if (!flush && !stall && in_valid && w_err && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end
  assign out_valid = r_stg[STAGES-1].valid;
  assign imm_ext   = r_stg[STAGES-1].data;
  assign out_err   = r_stg[STAGES-1].err;
  assign err_cnt   = r_cnt;
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed vectors against a behavioural pipeline model plus literal pins.
module tb_imm_ext_pipe;
  localparam int ST = 2;
  localparam int CW = 2;
  logic clk = 0, reset = 1, in_valid = 0, stall = 0, flush = 0, err_clr = 0;
  logic [31:0] ins = 0, pc4 = 0;
  logic [2:0] ext_op = 0;
  logic out_valid, out_err;
  logic [31:0] imm_ext;
  logic [CW-1:0] err_cnt;
  int total = 0, bad = 0;
  logic m_v [ST];
  logic [31:0] m_d [ST];
  logic m_e [ST];
  int m_cnt;

  imm_ext_pipe #(.DATA_W(32), .IMM_W(16), .JADDR_W(26), .STAGES(ST), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .ins(ins), .pc4(pc4), .ext_op(ext_op), .err_clr(err_clr),
    .out_valid(out_valid), .imm_ext(imm_ext), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_ext(input logic [2:0] op, input logic [31:0] i, input logic [31:0] p);
    logic [31:0] u, s;
    u = i & 32'h0000_FFFF;
    s = (u >= 32'h8000) ? u - 32'h1_0000 : u;
    case (op)
      3'd0: return u;
      3'd1: return s;
      3'd2: return u * 32'h1_0000;
      3'd3: return s * 4;
      3'd4: return (p & 32'hF000_0000) | ((i & 32'h03FF_FFFF) * 4);
      3'd5: return (i / 64) % 32;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ST; i++) begin m_v[i] = 0; m_d[i] = 0; m_e[i] = 0; end
      m_cnt = 0;
    end else begin
      if (flush) begin
        for (int i = 0; i < ST; i++) begin m_v[i] = 0; m_d[i] = 0; m_e[i] = 0; end
      end else if (!stall) begin
        for (int i = ST - 1; i > 0; i--) begin m_v[i] = m_v[i-1]; m_d[i] = m_d[i-1]; m_e[i] = m_e[i-1]; end
        m_v[0] = in_valid;
        m_d[0] = in_valid ? ref_ext(ext_op, ins, pc4) : 32'h0;
        m_e[0] = in_valid && ext_op > 3'd5;
      end
      if (err_clr) m_cnt = 0;
      else if (in_valid && !flush && !stall && ext_op > 3'd5 && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
    end
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("model out_valid", {31'b0, out_valid}, {31'b0, m_v[ST-1]});
      chk("model imm_ext", imm_ext, m_d[ST-1]);
      chk("model out_err", {31'b0, out_err}, {31'b0, m_e[ST-1]});
      chk("model err_cnt", 32'(err_cnt), 32'(m_cnt));
    end
  end

  task automatic cyc(input logic v, input logic [2:0] op, input logic [31:0] i, input logic [31:0] p,
                     input logic st, input logic fl, input logic clr);
    in_valid = v; ext_op = op; ins = i; pc4 = p; stall = st; flush = fl; err_clr = clr;
    @(negedge clk);
  endtask

  initial begin
    #1;
    chk("reset out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset imm_ext", imm_ext, 32'h0);
    chk("reset err_cnt", 32'(err_cnt), 32'h0);
    @(negedge clk); #1 reset = 0;
    cyc(1, 3'd1, 32'h0000_8004, 0, 0, 0, 0);
    cyc(1, 3'd0, 32'h0000_8004, 0, 0, 0, 0);
    chk("SIGN", imm_ext, 32'hFFFF_8004);
    cyc(1, 3'd2, 32'h0000_1234, 0, 0, 0, 0);
    chk("ZERO", imm_ext, 32'h0000_8004);
    cyc(1, 3'd3, 32'h0000_FFFF, 0, 0, 0, 0);
    chk("LUI", imm_ext, 32'h1234_0000);
    cyc(1, 3'd4, 32'hFC00_00C1, 32'hBFC0_0004, 0, 0, 0);
    chk("BRANCH", imm_ext, 32'hFFFF_FFFC);
    cyc(1, 3'd5, 32'h0000_07C0, 0, 0, 0, 0);
    chk("JUMP", imm_ext, 32'hB000_0304);
    cyc(0, 3'd0, 0, 0, 0, 0, 0);
    chk("SHAMT", imm_ext, 32'h0000_001F);
    cyc(1, 3'd1, 32'h0000_8004, 0, 0, 0, 0);
    cyc(1, 3'd0, 32'h0000_0001, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 3'd2, 32'h0000_5555, 0, 1, 0, 0);
      chk("stall hold", imm_ext, 32'hFFFF_8004);
      chk("stall valid", {31'b0, out_valid}, 32'h1);
    end
    cyc(1, 3'd2, 32'h0000_5555, 0, 1, 1, 0);
    chk("flush valid", {31'b0, out_valid}, 32'h0);
    chk("flush data", imm_ext, 32'h0);
    cyc(0, 3'd0, 0, 0, 0, 0, 0);
    chk("bubble behind flush", {31'b0, out_valid}, 32'h0);
    cyc(1, 3'd6, 32'h0000_FFFF, 0, 0, 0, 0);
    cyc(1, 3'd6, 32'h0000_FFFF, 0, 1, 0, 0);
    cyc(1, 3'd7, 32'h0000_FFFF, 0, 0, 0, 0);
    chk("illegal cnt", 32'(err_cnt), 32'h2);
    chk("illegal out_err", {31'b0, out_err}, 32'h1);
    chk("illegal data", imm_ext, 32'h0);
    cyc(1, 3'd6, 0, 0, 0, 0, 1);
    chk("err_clr wins", 32'(err_cnt), 32'h0);
    for (int k = 0; k < 5; k++) cyc(1, 3'(6 + k % 2), 32'h1234_5678, 0, 0, 0, 0);
    chk("saturate", 32'(err_cnt), 32'h3);
    cyc(1, 3'd1, 32'h0000_7FFF, 0, 0, 0, 0);
    cyc(1, 3'd0, 32'h0000_0002, 0, 0, 0, 0);
    chk("pre-reset valid", {31'b0, out_valid}, 32'h1);
    in_valid = 0;
    #2 reset = 1;
    #1;
    chk("async reset valid", {31'b0, out_valid}, 32'h0);
    chk("async reset data", imm_ext, 32'h0);
    chk("async reset cnt", 32'(err_cnt), 32'h0);
    @(negedge clk); #1 reset = 0;
    cyc(1, 3'd2, 32'h0000_1234, 0, 0, 0, 0);
    chk("post-reset latency", {31'b0, out_valid}, 32'h0);
    cyc(0, 3'd0, 0, 0, 0, 0, 0);
    chk("post-reset valid", {31'b0, out_valid}, 32'h1);
    chk("post-reset data", imm_ext, 32'h1234_0000);
    cyc(0, 3'd0, 0, 0, 0, 0, 0);
    cyc(0, 3'd0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
